// File: rtl/led_mem_arb.sv
// led_mem_arb: arbiter/sequencer for the tester's LED state register.
// Two writers (UART command bytes, key pushes) share the register; at most
// one update is applied per clock, with one pending slot per source.
// Status reports go out through uart_tx via a small TX FSM.
// Optional build macro: LED_ARB_REPORT_EN -- when defined, every applied
// update schedules a report; otherwise only opcode 11 does.
module led_mem_arb #(
    parameter int               NBITS = 6,
    parameter logic [NBITS-1:0] INIT  = '0
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_uart_en,
    input  logic [7:0]       in_uart_data,
    input  logic             in_key_en,
    input  logic             in_tx_busy,
    input  logic             in_tx_done,
    output logic             out_tx_start,
    output logic [7:0]       out_tx_data,
    output logic [NBITS-1:0] out_mem,
    output logic [2:0]       out_cursor,
    output logic             out_drop
);

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_WAIT  = 2'd2
    } tx_state_t;

    // State registers
    logic [NBITS-1:0] r_mem;
    logic [2:0]       r_cursor;
    logic             r_key_pend;
    logic             r_uart_pend;
    logic [7:0]       r_uart_byte;
    logic             r_rpt_pend;
    logic             r_drop;
    tx_state_t        r_tx_state;
    logic             r_tx_start;
    logic [7:0]       r_tx_data;

    // Service selection: pending slots first, then fresh requests
    logic             w_svc_kp;
    logic             w_svc_up;
    logic             w_svc_kn;
    logic             w_svc_un;
    logic             w_do_key;
    logic             w_do_uart;
    logic [7:0]       w_ubyte;
    logic             w_key_free;
    logic             w_uart_free;
    logic             w_key_latch;
    logic             w_key_drop;
    logic             w_uart_latch;
    logic             w_uart_drop;
    logic [NBITS-1:0] w_key_mask;
    logic [NBITS-1:0] w_idx_mask;
    logic [NBITS-1:0] w_wr_all;
    logic [NBITS-1:0] w_mem_nxt;
    logic [2:0]       w_cur_nxt;
    logic             w_rpt_req;
    logic             w_tx_take;

    // Busy is observed only; sequencing relies on the done pulse.
    logic             w_unused_busy;
    assign w_unused_busy = in_tx_busy;

    assign w_svc_kp  = r_key_pend;
    assign w_svc_up  = !r_key_pend && r_uart_pend;
    assign w_svc_kn  = !r_key_pend && !r_uart_pend && in_key_en;
    assign w_svc_un  = !r_key_pend && !r_uart_pend && !in_key_en && in_uart_en;
    assign w_do_key  = w_svc_kp || w_svc_kn;
    assign w_do_uart = w_svc_up || w_svc_un;
    assign w_ubyte   = w_svc_up ? r_uart_byte : in_uart_data;

    // A slot emptied by service this cycle can take a new request
    assign w_key_free   = !r_key_pend || w_svc_kp;
    assign w_uart_free  = !r_uart_pend || w_svc_up;
    assign w_key_latch  = in_key_en && !w_svc_kn && w_key_free;
    assign w_key_drop   = in_key_en && !w_svc_kn && !w_key_free;
    assign w_uart_latch = in_uart_en && !w_svc_un && w_uart_free;
    assign w_uart_drop  = in_uart_en && !w_svc_un && !w_uart_free;

    // Shifting a one past the top bit leaves an empty mask, so indices
    // >= NBITS become harmless no-op updates.
    assign w_key_mask = NBITS'(8'd1 << r_cursor);
    assign w_idx_mask = NBITS'(8'd1 << w_ubyte[2:0]);
    assign w_wr_all   = NBITS'({2'b00, w_ubyte[5:0]});

`ifdef LED_ARB_REPORT_EN
    assign w_rpt_req = w_do_key || w_do_uart;
`else
    assign w_rpt_req = w_do_uart && (w_ubyte[7:6] == 2'b11);
`endif

    assign w_tx_take = (r_tx_state == TX_IDLE) && r_rpt_pend;

    // Next LED state and cursor from the single serviced request
    always_comb begin
        w_mem_nxt = r_mem;
        w_cur_nxt = r_cursor;
        if (w_do_key) begin
            w_mem_nxt = r_mem ^ w_key_mask;
            w_cur_nxt = (r_cursor == 3'(NBITS - 1)) ? 3'd0 : r_cursor + 3'd1;
        end else if (w_do_uart) begin
            case (w_ubyte[7:6])
                2'b00:   w_mem_nxt = w_wr_all;
                2'b01:   w_mem_nxt = r_mem | w_idx_mask;
                2'b10:   w_mem_nxt = r_mem & ~w_idx_mask;
                default: w_mem_nxt = r_mem;
            endcase
        end
    end

    // LED state, cursor, pending slots and drop pulse
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_mem       <= INIT;
            r_cursor    <= 3'd0;
            r_key_pend  <= 1'b0;
            r_uart_pend <= 1'b0;
            r_uart_byte <= 8'd0;
            r_drop      <= 1'b0;
        end else begin
            r_mem       <= w_mem_nxt;
            r_cursor    <= w_cur_nxt;
            r_key_pend  <= w_key_latch || (r_key_pend && !w_svc_kp);
            r_uart_pend <= w_uart_latch || (r_uart_pend && !w_svc_up);
            if (w_uart_latch)
                r_uart_byte <= in_uart_data;
            r_drop      <= w_key_drop || w_uart_drop;
        end
    end

    // Report flag and TX sequencer; a request arriving as the flag is
    // consumed keeps it set for a follow-up report.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_rpt_pend <= 1'b0;
            r_tx_state <= TX_IDLE;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'd0;
        end else begin
            r_rpt_pend <= w_rpt_req || (r_rpt_pend && !w_tx_take);
            r_tx_start <= 1'b0;
            case (r_tx_state)
                TX_IDLE: begin
                    if (r_rpt_pend) begin
                        r_tx_state <= TX_START;
                        r_tx_start <= 1'b1;
                        r_tx_data  <= 8'(r_mem);
                    end
                end
                TX_START: r_tx_state <= TX_WAIT;
                TX_WAIT: begin
                    if (in_tx_done)
                        r_tx_state <= TX_IDLE;
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    assign out_mem      = r_mem;
    assign out_cursor   = r_cursor;
    assign out_drop     = r_drop;
    assign out_tx_start = r_tx_start;
    assign out_tx_data  = r_tx_data;

endmodule

// File: tb/tb_led_mem_arb.sv
// Self-checking bench for led_mem_arb (NBITS=6, INIT=0).
// A cycle-level reference model pushes expected LED/cursor/drop values
// per driven cycle; expected report bytes are pushed by the stimulus and
// popped when the DUT pulses out_tx_start. A simple uart_tx stand-in
// answers each start with a done pulse after a fixed delay.
module tb_led_mem_arb;

    logic       in_clk = 1'b0;
    logic       in_rst = 1'b1;
    logic       in_uart_en = 1'b0;
    logic [7:0] in_uart_data = 8'd0;
    logic       in_key_en = 1'b0;
    logic       in_tx_busy = 1'b0;
    logic       in_tx_done = 1'b0;
    logic       out_tx_start;
    logic [7:0] out_tx_data;
    logic [5:0] out_mem;
    logic [2:0] out_cursor;
    logic       out_drop;

`ifdef LED_ARB_REPORT_EN
    localparam bit ALL_RPT = 1'b1;
`else
    localparam bit ALL_RPT = 1'b0;
`endif

    led_mem_arb #(.NBITS(6), .INIT(6'd0)) dut (
        .in_clk(in_clk), .in_rst(in_rst),
        .in_uart_en(in_uart_en), .in_uart_data(in_uart_data),
        .in_key_en(in_key_en), .in_tx_busy(in_tx_busy), .in_tx_done(in_tx_done),
        .out_tx_start(out_tx_start), .out_tx_data(out_tx_data),
        .out_mem(out_mem), .out_cursor(out_cursor), .out_drop(out_drop)
    );

    always #5 in_clk = ~in_clk;

    typedef struct packed {
        logic [5:0] mem;
        logic [2:0] cur;
        logic       drop;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] exp_tx[$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         drop_cnt = 0;
    bit         tx_chk = 1'b1;
    int         tx_cnt = 0;
    int         tx_len = 10;

    // reference model state
    logic [5:0] m_mem = 6'd0;
    logic [2:0] m_cur = 3'd0;
    bit         m_kp = 1'b0;
    bit         m_up = 1'b0;
    logic [7:0] m_ub = 8'd0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic m_key();
        m_mem[m_cur] = ~m_mem[m_cur];
        m_cur = (m_cur == 3'd5) ? 3'd0 : m_cur + 3'd1;
    endtask

    task automatic m_uart(input logic [7:0] d);
        case (d[7:6])
            2'b00: m_mem = d[5:0];
            2'b01: if (d[2:0] < 3'd6) m_mem[d[2:0]] = 1'b1;
            2'b10: if (d[2:0] < 3'd6) m_mem[d[2:0]] = 1'b0;
            default: ;
        endcase
    endtask

    // One cycle of the reference: service one request, slot the rest
    task automatic m_step(input bit k, input bit u, input logic [7:0] d);
        bit k_done = 0, u_done = 0, drop = 0;
        if (m_kp) begin m_key(); m_kp = 0; end
        else if (m_up) begin m_uart(m_ub); m_up = 0; end
        else if (k) begin m_key(); k_done = 1; end
        else if (u) begin m_uart(d); u_done = 1; end
        if (k && !k_done) begin
            if (m_kp) drop = 1; else m_kp = 1;
        end
        if (u && !u_done) begin
            if (m_up) drop = 1; else begin m_up = 1; m_ub = d; end
        end
        exp_q.push_back('{mem: m_mem, cur: m_cur, drop: drop});
    endtask

    task automatic cyc(input bit k, input bit u, input logic [7:0] d);
        exp_t e;
        @(negedge in_clk);
        in_rst = 1'b0; in_key_en = k; in_uart_en = u; in_uart_data = d;
        m_step(k, u, d);
        @(posedge in_clk); #1;
        e = exp_q.pop_front();
        chk("mem", out_mem, e.mem);
        chk("cursor", out_cursor, e.cur);
        chk("drop", out_drop, e.drop);
        if (out_drop) drop_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 8'd0);
    endtask

    // Reset, optionally with a simultaneous request that must be lost
    task automatic do_reset(input bit k, input bit u, input logic [7:0] d);
        @(negedge in_clk);
        in_rst = 1'b1; in_key_en = k; in_uart_en = u; in_uart_data = d;
        m_mem = 6'd0; m_cur = 3'd0; m_kp = 0; m_up = 0;
        @(posedge in_clk); #1;
        chk("rst_mem", out_mem, 6'd0);
        chk("rst_cursor", out_cursor, 3'd0);
        chk("rst_drop", out_drop, 1'b0);
        chk("rst_tx_start", out_tx_start, 1'b0);
        chk("rst_tx_data", out_tx_data, 8'd0);
    endtask

    // uart_tx stand-in plus report scoreboard check
    initial begin
        forever begin
            @(negedge in_clk);
            in_tx_done = 1'b0;
            if (tx_cnt > 0) begin
                tx_cnt--;
                if (tx_cnt == 0) in_tx_done = 1'b1;
            end
            if (out_tx_start) begin
                if (tx_chk) begin
                    if (exp_tx.size() == 0) chk("tx_unexpected_start", 1, 0);
                    else chk("tx_data", out_tx_data, exp_tx.pop_front());
                end
                tx_cnt = tx_len;
            end
            in_tx_busy = (tx_cnt > 0);
        end
    end

    initial begin
        repeat (2) @(posedge in_clk);
        do_reset(0, 0, 8'd0);

        // write all 0x15
        if (ALL_RPT) exp_tx.push_back(8'h15);
        cyc(0, 1, 8'h15);
        chk("t1_mem", out_mem, 6'b010101);
        idle(30);
        chk("t1_tx_seen", exp_tx.size(), 0);

        // seven key pushes wrap the cursor
        tx_chk = !ALL_RPT;
        do_reset(0, 0, 8'd0);
        for (int i = 0; i < 7; i++) cyc(1, 0, 8'd0);
        chk("t2_mem", out_mem, 6'b111110);
        chk("t2_cursor", out_cursor, 3'd1);

        // simultaneous key and set-bit-3
        do_reset(0, 0, 8'd0);
        cyc(1, 1, 8'h43);
        chk("t3_mem_c1", out_mem, 6'b000001);
        cyc(0, 0, 8'd0);
        chk("t3_mem_c2", out_mem, 6'b001001);
        chk("t3_no_drop", out_drop, 1'b0);

        // both slots kept busy; third UART byte is dropped
        do_reset(0, 0, 8'd0);
        drop_cnt = 0;
        cyc(1, 1, 8'h41);
        cyc(1, 1, 8'h42);
        cyc(1, 1, 8'h43);
        idle(4);
        chk("t4_drop_count", drop_cnt, 1);
        chk("t4_bit3_clear", out_mem[3], 1'b0);
        idle(30);
        tx_chk = 1'b1;

        // report, then updates during TX_WAIT merge into one report
        do_reset(0, 0, 8'd0);
        exp_tx.push_back(8'h00);
        cyc(0, 1, 8'hC0);
        idle(3);
        cyc(0, 1, 8'h07);
        cyc(0, 1, 8'hC0);
        cyc(0, 1, 8'h4F);
        chk("t5_idx_oob", out_mem, 6'b000111);
        cyc(0, 1, 8'h8A);
        exp_tx.push_back(8'h03);
        idle(30);
        chk("t5_tx_all_seen", exp_tx.size(), 0);

        // reset during TX_WAIT with a report pending
        do_reset(0, 0, 8'd0);
        cyc(0, 1, 8'h2A);
        exp_tx.push_back(8'h2A);
        cyc(0, 1, 8'hC0);
        idle(3);
        cyc(0, 1, 8'hC0);
        idle(1);
        do_reset(1, 1, 8'h41);
        idle(25);
        chk("t6_tx_q_empty", exp_tx.size(), 0);
        chk("t6_mem", out_mem, 6'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
